// File: rtl/mock_cu_multi_if.sv
// Parallel-channel "B" bus and tag bundle between the channel engine and a control unit.
// master = channel side (drives *_out tags), slave = control-unit side (drives *_in tags).
interface mock_cu_multi_if;
    logic [7:0] b_bus_out;
    logic [7:0] b_bus_in;
    logic       b_operational_out;
    logic       b_hold_out;
    logic       b_select_out;
    logic       b_address_out;
    logic       b_command_out;
    logic       b_service_out;
    logic       b_suppress_out;
    logic       b_operational_in;
    logic       b_request_in;
    logic       b_select_in;
    logic       b_address_in;
    logic       b_status_in;
    logic       b_service_in;

    modport master (
        output b_bus_out, b_operational_out, b_hold_out, b_select_out,
               b_address_out, b_command_out, b_service_out, b_suppress_out,
        input  b_bus_in, b_operational_in, b_request_in, b_select_in,
               b_address_in, b_status_in, b_service_in
    );

    modport slave (
        input  b_bus_out, b_operational_out, b_hold_out, b_select_out,
               b_address_out, b_command_out, b_service_out, b_suppress_out,
        output b_bus_in, b_operational_in, b_request_in, b_select_in,
               b_address_in, b_status_in, b_service_in
    );
endinterface

// File: rtl/mock_cu_multi.sv
// Mock multi-device control unit: answers NUM_DEVICES addresses from ADDRESS_BASE, all in-tags registered.
// Optional macro MOCK_CU_SUPPRESS_EN: hold off raising service_in while suppress_out is high.
module mock_cu_multi #(
    parameter logic [7:0] ADDRESS_BASE      = 8'h10,
    parameter int         NUM_DEVICES       = 4,
    parameter bit         ENABLE_SHORT_BUSY = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mock_cu_multi_if.slave         b,
    output logic                   a_select_out,
    input  logic                   a_select_in,
    input  logic [NUM_DEVICES-1:0] mock_busy,
    input  logic [7:0]             mock_limit,
    output logic [7:0]             command,
    output logic [3:0]             device,
    output logic [7:0]             count,
    output logic                   done
);

    localparam logic [7:0] CMD_TIO   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'h03;
    localparam logic [7:0] CMD_SENSE = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_SBUSY, S_SB_SVC, S_SB_CMD, S_ADDR, S_CMDW,
        S_DECIDE, S_INIT, S_INIT_W, S_XFER, S_XFER_W, S_STOP_W, S_END
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        command_q, command_d;
    logic [3:0]        device_q, device_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        limit_q, limit_d;
    logic [7:0]        status_q, status_d;
    logic              send_q, send_d;
    logic [15:0][7:0]  sense_q, sense_d;
    logic              done_d;

    logic              op_in_q, op_in_d;
    logic              addr_in_q, addr_in_d;
    logic              stat_in_q, stat_in_d;
    logic              svc_in_q, svc_in_d;
    logic              sel_in_q;
    logic              a_sel_q, a_sel_d;
    logic [7:0]        bus_in_q, bus_in_d;
    logic              done_q;

    logic [15:0]       busy_pad;
    logic [7:0]        sel_offset;
    logic              sel_match;
    logic              unused_ok;

    assign busy_pad   = 16'(mock_busy);
    // Unsigned subtraction: addresses below ADDRESS_BASE wrap high and never match.
    assign sel_offset = b.b_bus_out - ADDRESS_BASE;
    assign sel_match  = b.b_operational_out && b.b_address_out && b.b_select_out &&
                        (sel_offset < 8'(NUM_DEVICES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        command_d = command_q;
        device_d  = device_q;
        count_d   = count_q;
        limit_d   = limit_q;
        status_d  = status_q;
        send_d    = send_q;
        sense_d   = sense_q;
        done_d    = 1'b0;
        if (!b.b_operational_out) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (sel_match) begin
                    device_d = sel_offset[3:0];
                    state_d  = S_SEL;
                end
                S_SEL: begin
                    if (busy_pad[device_q] && ENABLE_SHORT_BUSY) state_d = S_SBUSY;
                    else if (!b.b_address_out)                 state_d = S_ADDR;
                end
                S_SBUSY: begin
                    if (b.b_service_out)      state_d = S_SB_SVC;
                    else if (b.b_command_out) state_d = S_SB_CMD;
                end
                S_SB_SVC: if (!b.b_service_out) state_d = S_IDLE;
                S_SB_CMD: if (!b.b_command_out) state_d = S_IDLE;
                S_ADDR: if (b.b_command_out) begin
                    command_d = b.b_bus_out;
                    state_d   = S_CMDW;
                end
                S_CMDW: if (!b.b_command_out) state_d = S_DECIDE;
                S_DECIDE: begin
                    state_d = S_INIT;
                    if (busy_pad[device_q]) begin
                        status_d = 8'h08;
                    end else begin
                        case (command_q)
                            CMD_TIO, CMD_WRITE, CMD_READ, CMD_SENSE: status_d = 8'h00;
                            CMD_NOP: status_d = 8'h30;
                            default: begin
                                status_d              = 8'h70;
                                sense_d[device_q][7] = 1'b1;
                            end
                        endcase
                    end
                end
                S_INIT: if (b.b_service_out) state_d = S_INIT_W;
                S_INIT_W: if (!b.b_service_out) begin
                    if (status_q == 8'h00 && (command_q == CMD_WRITE ||
                        command_q == CMD_READ || command_q == CMD_SENSE)) begin
                        state_d = S_XFER;
                        count_d = 8'h00;
                        send_d  = (command_q != CMD_WRITE);
                        limit_d = (command_q == CMD_SENSE) ? 8'd1 : mock_limit;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // Only a raised service_in can be answered or stopped.
                S_XFER: if (svc_in_q) begin
                    if (b.b_service_out) begin
                        count_d = count_q + 8'd1;
                        state_d = S_XFER_W;
                    end else if (b.b_command_out) begin
                        state_d = S_STOP_W;
                    end
                end
                // Limit 0 completes when the 8-bit count wraps back to 0.
                S_XFER_W: if (!b.b_service_out) begin
                    state_d = (count_q == limit_q) ? S_END : S_XFER;
                end
                S_STOP_W: if (!b.b_command_out) state_d = S_END;
                S_END: if (b.b_service_out) begin
                    if (command_q == CMD_SENSE) sense_d[device_q] = 8'h00;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Tag outputs are derived from the next state so they appear with the state change.
    always_comb begin
        op_in_d   = (state_d != S_IDLE);
        addr_in_d = (state_d == S_ADDR);
        stat_in_d = (state_d == S_SBUSY) || (state_d == S_INIT) || (state_d == S_END);
        svc_in_d  = (state_d == S_XFER);
`ifdef MOCK_CU_SUPPRESS_EN
        if (state_d == S_XFER && !svc_in_q && b.b_suppress_out) svc_in_d = 1'b0;
`endif
        a_sel_d   = (state_q == S_IDLE) && b.b_select_out && !sel_match;
        case (state_d)
            S_ADDR:  bus_in_d = ADDRESS_BASE + {4'b0000, device_d};
            S_SBUSY: bus_in_d = 8'h48;
            S_INIT:  bus_in_d = status_d;
            S_XFER: begin
                if (!send_d)                   bus_in_d = 8'h00;
                else if (command_d == CMD_SENSE) bus_in_d = sense_d[device_d];
                else                           bus_in_d = count_d + 8'd1;
            end
            S_END:   bus_in_d = 8'h30;
            default: bus_in_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            command_q <= 8'h00;
            device_q  <= 4'h0;
            count_q   <= 8'h00;
            limit_q   <= 8'h00;
            status_q  <= 8'h00;
            send_q    <= 1'b0;
            sense_q   <= '0;
            op_in_q   <= 1'b0;
            addr_in_q <= 1'b0;
            stat_in_q <= 1'b0;
            svc_in_q  <= 1'b0;
            sel_in_q  <= 1'b0;
            a_sel_q   <= 1'b0;
            bus_in_q  <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            command_q <= command_d;
            device_q  <= device_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            status_q  <= status_d;
            send_q    <= send_d;
            sense_q   <= sense_d;
            op_in_q   <= op_in_d;
            addr_in_q <= addr_in_d;
            stat_in_q <= stat_in_d;
            svc_in_q  <= svc_in_d;
            sel_in_q  <= a_select_in;
            a_sel_q   <= a_sel_d;
            bus_in_q  <= bus_in_d;
            done_q    <= done_d;
        end
    end

    assign b.b_bus_in         = bus_in_q;
    assign b.b_operational_in = op_in_q;
    assign b.b_request_in     = 1'b0;
    assign b.b_select_in      = sel_in_q;
    assign b.b_address_in     = addr_in_q;
    assign b.b_status_in      = stat_in_q;
    assign b.b_service_in     = svc_in_q;
    assign a_select_out       = a_sel_q;
    assign command            = command_q;
    assign device             = device_q;
    assign count              = count_q;
    assign done               = done_q;

`ifdef MOCK_CU_SUPPRESS_EN
    assign unused_ok = b.b_hold_out;
`else
    assign unused_ok = b.b_hold_out ^ b.b_suppress_out;
`endif

endmodule

// File: tb/tb_mock_cu_multi.sv
// Scoreboard bench for mock_cu_multi: stimulus queues expected bus_in/done events, a monitor checks them.
module tb_mock_cu_multi;
    localparam logic [1:0] K_ADDR = 2'd0, K_STAT = 2'd1, K_DATA = 2'd2, K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic       a_select_out, a_select_in;
    logic [3:0] mock_busy;
    logic [7:0] mock_limit;
    logic [7:0] command;
    logic [3:0] device;
    logic [7:0] count;
    logic       done;

    int  checks = 0;
    int  errors = 0;
    ev_t sbq[$];
    logic p_addr = 1'b0, p_stat = 1'b0, p_svc = 1'b0, p_done = 1'b0;

    mock_cu_multi_if bif ();

    mock_cu_multi #(.ADDRESS_BASE(8'h10), .NUM_DEVICES(4), .ENABLE_SHORT_BUSY(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .b(bif),
        .a_select_out(a_select_out), .a_select_in(a_select_in),
        .mock_busy(mock_busy), .mock_limit(mock_limit),
        .command(command), .device(device), .count(count), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=%02h required=none", kind, data);
        end else begin
            e = sbq.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                errors++;
                $display("FAIL event actual kind=%0d data=%02h required kind=%0d data=%02h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bif.b_address_in && !p_addr) check_ev(K_ADDR, bif.b_bus_in);
        if (bif.b_status_in  && !p_stat) check_ev(K_STAT, bif.b_bus_in);
        if (bif.b_service_in && !p_svc)  check_ev(K_DATA, bif.b_bus_in);
        if (done && !p_done)             check_ev(K_DONE, count);
        p_addr = bif.b_address_in;
        p_stat = bif.b_status_in;
        p_svc  = bif.b_service_in;
        p_done = done;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input int sel, input logic val, input string nm);
        logic cur;
        for (int i = 0; i < 600; i++) begin
            case (sel)
                0:       cur = bif.b_operational_in;
                1:       cur = bif.b_address_in;
                2:       cur = bif.b_status_in;
                default: cur = bif.b_service_in;
            endcase
            if (cur === val) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s actual=stuck required=%0b", nm, val);
    endtask

    task automatic select_cmd(input logic [7:0] addr, input logic [7:0] cmd);
        bif.b_bus_out     = addr;
        bif.b_address_out = 1'b1;
        bif.b_select_out  = 1'b1;
        wait_for(0, 1'b1, "op_in");
        bif.b_address_out = 1'b0;
        bif.b_select_out  = 1'b0;
        wait_for(1, 1'b1, "addr_in");
        bif.b_bus_out     = cmd;
        bif.b_command_out = 1'b1;
        wait_for(1, 1'b0, "addr_in_drop");
        bif.b_command_out = 1'b0;
    endtask

    task automatic accept_status();
        wait_for(2, 1'b1, "status_in");
        bif.b_service_out = 1'b1;
        wait_for(2, 1'b0, "status_in_drop");
        bif.b_service_out = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] wdata);
        wait_for(3, 1'b1, "service_in");
        bif.b_bus_out     = wdata;
        bif.b_service_out = 1'b1;
        wait_for(3, 1'b0, "service_in_drop");
        bif.b_service_out = 1'b0;
    endtask

    task automatic stop_xfer();
        wait_for(3, 1'b1, "service_in_stop");
        bif.b_command_out = 1'b1;
        wait_for(3, 1'b0, "service_in_stop_drop");
        bif.b_command_out = 1'b0;
    endtask

    task automatic chk_tags_low(input string nm);
        chk({nm, "_op_in"},   8'(bif.b_operational_in), 8'h00);
        chk({nm, "_addr_in"}, 8'(bif.b_address_in), 8'h00);
        chk({nm, "_stat_in"}, 8'(bif.b_status_in), 8'h00);
        chk({nm, "_svc_in"},  8'(bif.b_service_in), 8'h00);
    endtask

    initial begin
        reset_n = 1'b0;
        a_select_in = 1'b0;
        mock_busy = 4'h0;
        mock_limit = 8'h00;
        bif.b_bus_out = 8'h00;
        bif.b_operational_out = 1'b0;
        bif.b_hold_out = 1'b0;
        bif.b_select_out = 1'b0;
        bif.b_address_out = 1'b0;
        bif.b_command_out = 1'b0;
        bif.b_service_out = 1'b0;
        bif.b_suppress_out = 1'b0;
        repeat (3) @(negedge clk);

        chk_tags_low("rst");
        chk("rst_bus_in", bif.b_bus_in, 8'h00);
        chk("rst_request_in", 8'(bif.b_request_in), 8'h00);
        chk("rst_select_in", 8'(bif.b_select_in), 8'h00);
        chk("rst_a_select_out", 8'(a_select_out), 8'h00);
        chk("rst_command", command, 8'h00);
        chk("rst_device", 8'(device), 8'h00);
        chk("rst_count", count, 8'h00);
        chk("rst_done", 8'(done), 8'h00);

        reset_n = 1'b1;
        bif.b_operational_out = 1'b1;
        repeat (2) @(negedge clk);

        // NOP to device 1
        push(K_ADDR, 8'h11); push(K_STAT, 8'h30); push(K_DONE, 8'h00);
        select_cmd(8'h11, 8'h03);
        accept_status();
        repeat (3) @(negedge clk);
        chk("nop_device", 8'(device), 8'h01);
        chk("nop_command", command, 8'h03);
        chk("nop_idle_op_in", 8'(bif.b_operational_in), 8'h00);

        // READ 3 bytes from device 0
        mock_limit = 8'd3;
        push(K_ADDR, 8'h10); push(K_STAT, 8'h00);
        push(K_DATA, 8'h01); push(K_DATA, 8'h02); push(K_DATA, 8'h03);
        push(K_STAT, 8'h30); push(K_DONE, 8'h03);
        select_cmd(8'h10, 8'h02);
        accept_status();
        for (int i = 0; i < 3; i++) xfer_byte(8'h00);
        accept_status();
        repeat (2) @(negedge clk);
        chk("read_count", count, 8'h03);

        // WRITE with limit 0 (256), stopped after 5 bytes
        mock_limit = 8'd0;
        push(K_ADDR, 8'h13); push(K_STAT, 8'h00);
        for (int i = 0; i < 6; i++) push(K_DATA, 8'h00);
        push(K_STAT, 8'h30); push(K_DONE, 8'h05);
        select_cmd(8'h13, 8'h01);
        accept_status();
        for (int i = 0; i < 5; i++) xfer_byte(8'(8'hA0 + i));
        stop_xfer();
        accept_status();
        repeat (2) @(negedge clk);
        chk("write_stop_count", count, 8'h05);

        // Command reject then two SENSEs on device 2
        push(K_ADDR, 8'h12); push(K_STAT, 8'h70); push(K_DONE, 8'h05);
        select_cmd(8'h12, 8'h7F);
        accept_status();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            push(K_ADDR, 8'h12); push(K_STAT, 8'h00);
            push(K_DATA, (k == 0) ? 8'h80 : 8'h00);
            push(K_STAT, 8'h30); push(K_DONE, 8'h01);
            select_cmd(8'h12, 8'h04);
            accept_status();
            xfer_byte(8'h00);
            accept_status();
            repeat (2) @(negedge clk);
        end

        // Short busy on device 2
        mock_busy = 4'b0100;
        push(K_STAT, 8'h48);
        bif.b_bus_out = 8'h12;
        bif.b_address_out = 1'b1;
        bif.b_select_out = 1'b1;
        wait_for(2, 1'b1, "sbusy_status");
        chk("sbusy_no_addr_in", 8'(bif.b_address_in), 8'h00);
        bif.b_service_out = 1'b1;
        wait_for(2, 1'b0, "sbusy_drop");
        bif.b_address_out = 1'b0;
        bif.b_select_out = 1'b0;
        bif.b_service_out = 1'b0;
        repeat (3) @(negedge clk);
        mock_busy = 4'h0;
        chk("sbusy_idle_op_in", 8'(bif.b_operational_in), 8'h00);

        // Out-of-range addresses forward select-out
        bif.b_bus_out = 8'h14;
        bif.b_address_out = 1'b1;
        bif.b_select_out = 1'b1;
        repeat (2) @(negedge clk);
        chk("fwd_14_a_select", 8'(a_select_out), 8'h01);
        chk("fwd_14_op_in", 8'(bif.b_operational_in), 8'h00);
        bif.b_bus_out = 8'h0F;
        repeat (2) @(negedge clk);
        chk("fwd_0f_a_select", 8'(a_select_out), 8'h01);
        chk("fwd_0f_op_in", 8'(bif.b_operational_in), 8'h00);
        bif.b_select_out = 1'b0;
        bif.b_address_out = 1'b0;
        repeat (2) @(negedge clk);
        chk("fwd_drop_a_select", 8'(a_select_out), 8'h00);
        a_select_in = 1'b1;
        @(negedge clk);
        chk("select_in_copy", 8'(bif.b_select_in), 8'h01);
        a_select_in = 1'b0;
        @(negedge clk);
        chk("select_in_copy_low", 8'(bif.b_select_in), 8'h00);

        // operational_out dropped during READ
        mock_limit = 8'd10;
        push(K_ADDR, 8'h10); push(K_STAT, 8'h00);
        push(K_DATA, 8'h01); push(K_DATA, 8'h02);
        select_cmd(8'h10, 8'h02);
        accept_status();
        xfer_byte(8'h00);
        wait_for(3, 1'b1, "svc_before_opdrop");
        bif.b_operational_out = 1'b0;
        @(negedge clk);
        chk_tags_low("opdrop");
        chk("opdrop_count_kept", count, 8'h01);
        chk("opdrop_command_kept", command, 8'h02);
        bif.b_operational_out = 1'b1;
        repeat (2) @(negedge clk);

        // Async reset during READ
        push(K_ADDR, 8'h10); push(K_STAT, 8'h00); push(K_DATA, 8'h01);
        select_cmd(8'h10, 8'h02);
        accept_status();
        wait_for(3, 1'b1, "svc_before_reset");
        #2 reset_n = 1'b0;
        #1;
        chk_tags_low("arst");
        chk("arst_bus_in", bif.b_bus_in, 8'h00);
        chk("arst_count", count, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 8'(sbq.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
